mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Parametrised multi-cycle successor to the single-cycle MIPS controller: a Moore FSM that sequences fetch, decode, execute, memory and write-back over several cycles against a shared instruction/data memory. Adds a memory-ready handshake, a multi-cycle multiply/divide unit with configurable latency, and `bne`, `jr`, `jal`, `mfhi`/`mflo` and illegal-opcode detection. Sits beside the multi-cycle datapath under the MIPS32 top and drives every datapath select and enable.

## Interface
- `MULDIV_LAT`, default 4: cycles spent in MULDIV. Legal range is 1..32.
- `MEM_WAIT_EN`, default 1: when 1, `mem_ready` gates memory states. When 0, `mem_ready` is treated as constant 1.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `opcode` in 6: IR[31:26]. `func` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access.
- `pc_write`, `ir_write`, `i_or_d`, `mem_read`, `mem_write`, `reg_write` out 1 each: datapath enables.
- `reg_dst` out 2: 00 rt, 01 rd, 10 $31.
- `mem_to_reg` out 2: 00 ALUOut, 01 MDR, 10 PC, 11 HI/LO.
- `alu_src_a` out 1: 0 PC, 1 A.
- `alu_src_b` out 2: 00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `alu_op` out 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT.
- `pc_src` out 2: 00 ALU result, 01 ALUOut, 10 jump target, 11 A (jr).
- `hilo_sel` out 1: 0 LO, 1 HI.
- `muldiv_start`, `hilo_write`, `muldiv_is_div` out 1 each: control of the mult/div unit.
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.
- `illegal` out 1: one-cycle pulse when an unsupported opcode or func is decoded.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, RWB, IWB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JAL, JR, MULDIV, MFHL.
- Every output not listed for a state is 0.
- **FETCH:** `i_or_d`=0, `mem_read`=1, `alu_src_b`=01, ADD, `pc_src`=00. `ir_write`=`pc_write`=`mem_ready`. Advances to DECODE only when `mem_ready`=1.
- **DECODE:** `alu_src_b`=11, ADD (branch target into ALUOut). Dispatch:
  - R-type, func 0x20/0x22/0x24/0x25/0x2A → EXEC_R.
  - func 0x08 → JR.
  - func 0x18/0x1A → MULDIV.
  - func 0x10/0x12 → MFHL.
  - addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D → EXEC_I.
  - lw 0x23, sw 0x2B → MEM_ADDR.
  - beq 0x04, bne 0x05 → BRANCH.
  - j 0x02 → JUMP; jal 0x03 → JAL.
  - Anything else: `illegal`=1 and `instr_done`=1 in DECODE, then → FETCH.
- **EXEC_R:** `alu_src_a`=1, `alu_src_b`=00, `alu_op` from func → RWB.
- **RWB:** `reg_write`=1, `reg_dst`=01, `mem_to_reg`=00.
- **EXEC_I:** `alu_src_a`=1, `alu_src_b`=10, `alu_op` from opcode → IWB.
- **IWB:** `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00.
- **MEM_ADDR:** `alu_src_a`=1, `alu_src_b`=10, ADD → MEM_RD for lw, MEM_WR for sw.
- **MEM_RD:** `i_or_d`=1, `mem_read`=1; held until `mem_ready`, then → MEM_WB.
- **MEM_WB:** `reg_write`=1, `reg_dst`=00, `mem_to_reg`=01.
- **MEM_WR:** `i_or_d`=1, `mem_write`=1; held until `mem_ready`.
- **BRANCH:** `alu_src_a`=1, `alu_src_b`=00, SUB, `pc_src`=01, `pc_write` = `zero` XOR (opcode==bne).
- **JUMP:** `pc_write`=1, `pc_src`=10.
- **JAL:** as JUMP, plus `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10 (PC already +4).
- **JR:** `pc_write`=1, `pc_src`=11.
- **MULDIV:**
  - On entry, a 5-bit down-counter is loaded with `MULDIV_LAT`-1.
  - `muldiv_start`=1 only in the first cycle; `muldiv_is_div`=(func==0x1A) throughout.
  - `hilo_write`=1 in the cycle the counter is 0.
  - With `MULDIV_LAT`=1, start and hilo_write occur in the same cycle.
- **MFHL:** `reg_write`=1, `reg_dst`=01, `mem_to_reg`=11, `hilo_sel`=(func==0x10).
- `instr_done`=1 in RWB, IWB, MEM_WB, the completing cycle of MEM_WR, BRANCH, JUMP, JAL, JR, the final MULDIV cycle, and MFHL. Each of these returns to FETCH.

## Timing
- Outputs are combinational from state, `opcode`, `func`, `zero`, `mem_ready` and the counter. The next state is registered.
- While `rst`=0 at an edge, the next state is FETCH and the counter is 0. All outputs are forced to 0 during cycles in which `rst`=0.
- The first cycle after release is FETCH with `mem_read`=1.
- Reset asserted mid-instruction aborts it; no write enable pulses afterwards.
- Latency with `mem_ready`=1, counted FETCH through `instr_done`:
  - R/I/MFHL: 4.
  - lw: 5. sw: 4.
  - beq/bne/j/jal/jr: 3.
  - mult/div: 2+`MULDIV_LAT`.
  - illegal: 2.
- Each cycle of `mem_ready`=0 in FETCH/MEM_RD/MEM_WR adds exactly one cycle. Strobes stay stable while waiting.

## Structure
- `mips_pkg` holds:
  - the state enum;
  - opcode/func localparams;
  - the `alu_op`, `pc_src`, `reg_dst`, `mem_to_reg` and `alu_src_b` encodings.
- One sub-module, `mips_alu_ctrl`: combinational (opcode, func) → `alu_op`, `legal`. Shared by EXEC_R, EXEC_I and DECODE.

## Test plan
- add (op 0, func 0x20), `mem_ready`=1 → states FETCH, DECODE, EXEC_R, RWB. RWB has `reg_write`=1, `reg_dst`=01, `alu_op`=000 in EXEC_R; `instr_done` in cycle 4.
- lw (0x23), `mem_ready`=0 for 2 cycles in MEM_RD → `mem_read`=1, `i_or_d`=1 for 3 cycles; MEM_WB `mem_to_reg`=01; `instr_done` in cycle 7.
- beq with `zero`=1 → `pc_write`=1, `pc_src`=01. bne with `zero`=1 → `pc_write`=0. Both take 3 cycles.
- mult (func 0x18), `MULDIV_LAT`=4 → single `muldiv_start` in cycle 3, `hilo_write` in cycle 6 with `instr_done`; repeat with `MULDIV_LAT`=1 → start and write coincide in cycle 3.
- jal (0x03) → cycle 3 has `pc_write`=1, `pc_src`=10, `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10.
- opcode 0x3F → `illegal` and `instr_done` in cycle 2, then FETCH. `rst`=0 during MEM_WB of lw → `reg_write`=0, FETCH on the cycle after release.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multi-cycle MIPS controller.
//   - state_t          : controller FSM states
//   - OP_* / FN_*      : opcode (IR[31:26]) and R-type func (IR[5:0]) values
//   - ALU_*, PC_*, RD_*, MTR_*, SRCB_* : datapath select encodings
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, RWB, IWB, MEM_ADDR, MEM_RD,
    MEM_WB, MEM_WR, BRANCH, JUMP, JAL, JR, MULDIV, MFHL
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type func codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // alu_op
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // pc_src
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  // reg_dst
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // mem_to_reg
  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_MDR  = 2'b01;
  localparam logic [1:0] MTR_PC   = 2'b10;
  localparam logic [1:0] MTR_HILO = 2'b11;

  // alu_src_b
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mips_alu_ctrl.sv
// mips_alu_ctrl: combinational ALU operation decode.
//   opcode, func : instruction fields
//   alu_op       : ALU operation for R-type (from func) or I-type (from opcode)
//   legal        : 1 when the (opcode, func) pair is a supported instruction
module mips_alu_ctrl
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [2:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_JR, FN_MULT, FN_DIV, FN_MFHI, FN_MFLO: alu_op = ALU_ADD;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: alu_op = ALU_ADD;
      OP_SLTI: alu_op = ALU_SLT;
      OP_ANDI: alu_op = ALU_AND;
      OP_ORI:  alu_op = ALU_OR;
      OP_LW, OP_SW:   alu_op = ALU_ADD;
      OP_BEQ, OP_BNE: alu_op = ALU_SUB;
      OP_J, OP_JAL:   alu_op = ALU_ADD;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: Moore-style multi-cycle MIPS control FSM.
//   Parameters: MULDIV_LAT (1..32) cycles in MULDIV; MEM_WAIT_EN gates memory
//   states on mem_ready (0 = memory always ready).
//   Inputs : clk, rst (sync, active-low), opcode, func, zero, mem_ready
//   Outputs: datapath enables/selects, mult/div control, instr_done and
//            illegal pulses. Outputs are combinational from the registered
//            state, the instruction fields, zero, mem_ready and the MULDIV
//            counter, and are all 0 while rst is low.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int MULDIV_LAT  = 4,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       hilo_sel,
  output logic       muldiv_start,
  output logic       hilo_write,
  output logic       muldiv_is_div,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [4:0] LAT_M1 = 5'(MULDIV_LAT - 1);

  state_t     state_reg;
  state_t     dispatch;
  logic [4:0] cnt_reg;
  logic [2:0] dec_alu_op;
  logic       dec_legal;
  logic       mem_ok;

  assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

  mips_alu_ctrl u_alu_ctrl (
    .opcode (opcode),
    .func   (func),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  // DECODE dispatch target; unsupported encodings fall back to FETCH.
  always_comb begin
    dispatch = FETCH;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: dispatch = EXEC_R;
          FN_JR:            dispatch = JR;
          FN_MULT, FN_DIV:  dispatch = MULDIV;
          FN_MFHI, FN_MFLO: dispatch = MFHL;
          default:          dispatch = FETCH;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: dispatch = EXEC_I;
      OP_LW, OP_SW:   dispatch = MEM_ADDR;
      OP_BEQ, OP_BNE: dispatch = BRANCH;
      OP_J:           dispatch = JUMP;
      OP_JAL:         dispatch = JAL;
      default:        dispatch = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= FETCH;
      cnt_reg   <= 5'd0;
    end else begin
      case (state_reg)
        FETCH:    if (mem_ok) state_reg <= DECODE;
        DECODE: begin
          state_reg <= dispatch;
          if (dispatch == MULDIV) cnt_reg <= LAT_M1;
        end
        EXEC_R:   state_reg <= RWB;
        EXEC_I:   state_reg <= IWB;
        MEM_ADDR: state_reg <= (opcode == OP_SW) ? MEM_WR : MEM_RD;
        MEM_RD:   if (mem_ok) state_reg <= MEM_WB;
        MEM_WR:   if (mem_ok) state_reg <= FETCH;
        MULDIV: begin
          if (cnt_reg == 5'd0) state_reg <= FETCH;
          else                 cnt_reg   <= cnt_reg - 5'd1;
        end
        default:  state_reg <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = RD_RT;
    mem_to_reg    = MTR_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_src        = PC_ALU;
    hilo_sel      = 1'b0;
    muldiv_start  = 1'b0;
    hilo_write    = 1'b0;
    muldiv_is_div = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    if (rst) begin
      case (state_reg)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          // PC+4 and IR load only once the instruction word is valid
          ir_write  = mem_ok;
          pc_write  = mem_ok;
        end
        DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          if (!dec_legal) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        end
        EXEC_R, EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = (state_reg == EXEC_R) ? SRCB_REG : SRCB_IMM;
          alu_op    = dec_alu_op;
        end
        RWB, IWB: begin
          reg_write  = 1'b1;
          reg_dst    = (state_reg == RWB) ? RD_RD : RD_RT;
          instr_done = 1'b1;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        MEM_RD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = MTR_MDR;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          i_or_d     = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ok;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = PC_ALUOUT;
          pc_write   = zero ^ (opcode == OP_BNE);
          instr_done = 1'b1;
        end
        JUMP, JAL: begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          instr_done = 1'b1;
          if (state_reg == JAL) begin
            reg_write  = 1'b1;
            reg_dst    = RD_RA;
            mem_to_reg = MTR_PC;
          end
        end
        JR: begin
          pc_write   = 1'b1;
          pc_src     = PC_REG;
          instr_done = 1'b1;
        end
        MULDIV: begin
          // counter sits at LAT-1 only in the entry cycle
          muldiv_start  = (cnt_reg == LAT_M1);
          muldiv_is_div = (func == FN_DIV);
          hilo_write    = (cnt_reg == 5'd0);
          instr_done    = (cnt_reg == 5'd0);
        end
        MFHL: begin
          reg_write  = 1'b1;
          reg_dst    = RD_RD;
          mem_to_reg = MTR_HILO;
          hilo_sel   = (func == FN_MFHI);
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller. Three instances share the stimulus:
// index 0 (MULDIV_LAT=4), index 1 (MULDIV_LAT=1), index 2 (MEM_WAIT_EN=0).
// Each table row is one clock cycle; its expected 24-bit output word is
// queued when the row is driven and popped/compared at the falling edge.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] func = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [23:0] o [3];

  always #5 clk = ~clk;

  // Output word layout:
  // 23 pc_write 22 ir_write 21 i_or_d 20 mem_read 19 mem_write 18 reg_write
  // 17:16 reg_dst 15:14 mem_to_reg 13 alu_src_a 12:11 alu_src_b 10:8 alu_op
  // 7:6 pc_src 5 hilo_sel 4 muldiv_start 3 hilo_write 2 muldiv_is_div
  // 1 instr_done 0 illegal
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      mips_mc_controller #(
        .MULDIV_LAT  ((gi == 1) ? 1 : 4),
        .MEM_WAIT_EN ((gi == 2) ? 1'b0 : 1'b1)
      ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .func          (func),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (o[gi][23]),
        .ir_write      (o[gi][22]),
        .i_or_d        (o[gi][21]),
        .mem_read      (o[gi][20]),
        .mem_write     (o[gi][19]),
        .reg_write     (o[gi][18]),
        .reg_dst       (o[gi][17:16]),
        .mem_to_reg    (o[gi][15:14]),
        .alu_src_a     (o[gi][13]),
        .alu_src_b     (o[gi][12:11]),
        .alu_op        (o[gi][10:8]),
        .pc_src        (o[gi][7:6]),
        .hilo_sel      (o[gi][5]),
        .muldiv_start  (o[gi][4]),
        .hilo_write    (o[gi][3]),
        .muldiv_is_div (o[gi][2]),
        .instr_done    (o[gi][1]),
        .illegal       (o[gi][0])
      );
    end
  endgenerate

  localparam logic [23:0] PCW  = 24'h800000;
  localparam logic [23:0] IRW  = 24'h400000;
  localparam logic [23:0] IOD  = 24'h200000;
  localparam logic [23:0] MRD  = 24'h100000;
  localparam logic [23:0] MWR  = 24'h080000;
  localparam logic [23:0] RW   = 24'h040000;
  localparam logic [23:0] SA   = 24'h002000;
  localparam logic [23:0] HSEL = 24'h000020;
  localparam logic [23:0] MST  = 24'h000010;
  localparam logic [23:0] HW   = 24'h000008;
  localparam logic [23:0] MDIV = 24'h000004;
  localparam logic [23:0] DONE = 24'h000002;
  localparam logic [23:0] ILL  = 24'h000001;

  function automatic logic [23:0] rd(input int v);  return 24'(v) << 16; endfunction
  function automatic logic [23:0] mtr(input int v); return 24'(v) << 14; endfunction
  function automatic logic [23:0] sb(input int v);  return 24'(v) << 11; endfunction
  function automatic logic [23:0] aop(input int v); return 24'(v) << 8;  endfunction
  function automatic logic [23:0] pcs(input int v); return 24'(v) << 6;  endfunction

  typedef struct {
    int          sel;
    logic        r;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [23:0] exp;
    string       nm;
  } vec_t;

  vec_t        vecs[$];
  logic [23:0] sb_q[$];
  int          checks = 0;
  int          failures = 0;

  function automatic void v(int sel, logic r, logic [5:0] op, logic [5:0] fn,
                            logic z, logic rdy, logic [23:0] exp, string nm);
    vec_t t;
    t.sel = sel; t.r = r; t.op = op; t.fn = fn; t.z = z; t.rdy = rdy;
    t.exp = exp; t.nm = nm;
    vecs.push_back(t);
  endfunction

  task automatic run_vec(input vec_t t);
    logic [23:0] e;
    @(posedge clk);
    #1;
    rst = t.r; opcode = t.op; func = t.fn; zero = t.z; mem_ready = t.rdy;
    sb_q.push_back(t.exp);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if (o[t.sel] !== e) begin
      failures++;
      $display("FAIL %s dut%0d got=%06h want=%06h", t.nm, t.sel, o[t.sel], e);
    end else
      $display("ok   %s dut%0d out=%06h", t.nm, t.sel, o[t.sel]);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] f_ok, f_wt, dec;
    f_ok = PCW | IRW | MRD | sb(1);
    f_wt = MRD | sb(1);
    dec  = sb(3);

    v(0, 0, 0, 0, 0, 1, 0, "reset0");
    v(0, 0, 0, 0, 0, 1, 0, "reset1");
    // add
    v(0, 1, 6'h00, 6'h20, 0, 1, f_ok, "add_fetch");
    v(0, 1, 6'h00, 6'h20, 0, 1, dec, "add_decode");
    v(0, 1, 6'h00, 6'h20, 0, 1, SA | aop(0), "add_exec");
    v(0, 1, 6'h00, 6'h20, 0, 1, RW | rd(1) | DONE, "add_rwb");
    // slt
    v(0, 1, 6'h00, 6'h2A, 0, 1, f_ok, "slt_fetch");
    v(0, 1, 6'h00, 6'h2A, 0, 1, dec, "slt_decode");
    v(0, 1, 6'h00, 6'h2A, 0, 1, SA | aop(4), "slt_exec");
    v(0, 1, 6'h00, 6'h2A, 0, 1, RW | rd(1) | DONE, "slt_rwb");
    // ori
    v(0, 1, 6'h0D, 6'h00, 0, 1, f_ok, "ori_fetch");
    v(0, 1, 6'h0D, 6'h00, 0, 1, dec, "ori_decode");
    v(0, 1, 6'h0D, 6'h00, 0, 1, SA | sb(2) | aop(3), "ori_exec");
    v(0, 1, 6'h0D, 6'h00, 0, 1, RW | DONE, "ori_iwb");
    // beq taken, bne not taken, bne taken
    v(0, 1, 6'h04, 6'h00, 1, 1, f_ok, "beq_fetch");
    v(0, 1, 6'h04, 6'h00, 1, 1, dec, "beq_decode");
    v(0, 1, 6'h04, 6'h00, 1, 1, PCW | SA | aop(1) | pcs(1) | DONE, "beq_z1");
    v(0, 1, 6'h05, 6'h00, 1, 1, f_ok, "bne_fetch");
    v(0, 1, 6'h05, 6'h00, 1, 1, dec, "bne_decode");
    v(0, 1, 6'h05, 6'h00, 1, 1, SA | aop(1) | pcs(1) | DONE, "bne_z1");
    v(0, 1, 6'h05, 6'h00, 0, 1, f_ok, "bne0_fetch");
    v(0, 1, 6'h05, 6'h00, 0, 1, dec, "bne0_decode");
    v(0, 1, 6'h05, 6'h00, 0, 1, PCW | SA | aop(1) | pcs(1) | DONE, "bne_z0");
    // j, jal, jr
    v(0, 1, 6'h02, 6'h00, 0, 1, f_ok, "j_fetch");
    v(0, 1, 6'h02, 6'h00, 0, 1, dec, "j_decode");
    v(0, 1, 6'h02, 6'h00, 0, 1, PCW | pcs(2) | DONE, "j_jump");
    v(0, 1, 6'h03, 6'h00, 0, 1, f_ok, "jal_fetch");
    v(0, 1, 6'h03, 6'h00, 0, 1, dec, "jal_decode");
    v(0, 1, 6'h03, 6'h00, 0, 1, PCW | pcs(2) | RW | rd(2) | mtr(2) | DONE, "jal_jal");
    v(0, 1, 6'h00, 6'h08, 0, 1, f_ok, "jr_fetch");
    v(0, 1, 6'h00, 6'h08, 0, 1, dec, "jr_decode");
    v(0, 1, 6'h00, 6'h08, 0, 1, PCW | pcs(3) | DONE, "jr_jr");
    // mfhi, mflo
    v(0, 1, 6'h00, 6'h10, 0, 1, f_ok, "mfhi_fetch");
    v(0, 1, 6'h00, 6'h10, 0, 1, dec, "mfhi_decode");
    v(0, 1, 6'h00, 6'h10, 0, 1, RW | rd(1) | mtr(3) | HSEL | DONE, "mfhi_mfhl");
    v(0, 1, 6'h00, 6'h12, 0, 1, f_ok, "mflo_fetch");
    v(0, 1, 6'h00, 6'h12, 0, 1, dec, "mflo_decode");
    v(0, 1, 6'h00, 6'h12, 0, 1, RW | rd(1) | mtr(3) | DONE, "mflo_mfhl");
    // illegal opcode and illegal func
    v(0, 1, 6'h3F, 6'h00, 0, 1, f_ok, "ill_fetch");
    v(0, 1, 6'h3F, 6'h00, 0, 1, dec | ILL | DONE, "ill_decode");
    v(0, 1, 6'h00, 6'h01, 0, 1, f_ok, "illfn_fetch");
    v(0, 1, 6'h00, 6'h01, 0, 1, dec | ILL | DONE, "illfn_decode");
    // lw with two wait cycles in MEM_RD (instance 2 diverges; resync by reset)
    v(0, 1, 6'h23, 6'h00, 0, 1, f_ok, "lw_fetch");
    v(0, 1, 6'h23, 6'h00, 0, 1, dec, "lw_decode");
    v(0, 1, 6'h23, 6'h00, 0, 1, SA | sb(2), "lw_addr");
    v(0, 1, 6'h23, 6'h00, 0, 0, IOD | MRD, "lw_rd_wait1");
    v(0, 1, 6'h23, 6'h00, 0, 0, IOD | MRD, "lw_rd_wait2");
    v(0, 1, 6'h23, 6'h00, 0, 1, IOD | MRD, "lw_rd_ready");
    v(0, 1, 6'h23, 6'h00, 0, 1, RW | mtr(1) | DONE, "lw_wb");
    v(0, 0, 6'h00, 6'h00, 0, 1, 0, "resync1");
    // sw with fetch wait and write wait
    v(0, 1, 6'h2B, 6'h00, 0, 0, f_wt, "sw_fetch_wait");
    v(0, 1, 6'h2B, 6'h00, 0, 1, f_ok, "sw_fetch");
    v(0, 1, 6'h2B, 6'h00, 0, 1, dec, "sw_decode");
    v(0, 1, 6'h2B, 6'h00, 0, 1, SA | sb(2), "sw_addr");
    v(0, 1, 6'h2B, 6'h00, 0, 0, IOD | MWR, "sw_wr_wait");
    v(0, 1, 6'h2B, 6'h00, 0, 1, IOD | MWR | DONE, "sw_wr_done");
    v(0, 0, 6'h00, 6'h00, 0, 1, 0, "resync2");
    // mult, MULDIV_LAT=4
    v(0, 1, 6'h00, 6'h18, 0, 1, f_ok, "mult4_fetch");
    v(0, 1, 6'h00, 6'h18, 0, 1, dec, "mult4_decode");
    v(0, 1, 6'h00, 6'h18, 0, 1, MST, "mult4_c3");
    v(0, 1, 6'h00, 6'h18, 0, 1, 0, "mult4_c4");
    v(0, 1, 6'h00, 6'h18, 0, 1, 0, "mult4_c5");
    v(0, 1, 6'h00, 6'h18, 0, 1, HW | DONE, "mult4_c6");
    v(0, 1, 6'h00, 6'h18, 0, 1, f_ok, "mult4_next_fetch");
    v(0, 0, 6'h00, 6'h00, 0, 1, 0, "resync3");
    // mult and div, MULDIV_LAT=1
    v(1, 1, 6'h00, 6'h18, 0, 1, f_ok, "mult1_fetch");
    v(1, 1, 6'h00, 6'h18, 0, 1, dec, "mult1_decode");
    v(1, 1, 6'h00, 6'h18, 0, 1, MST | HW | DONE, "mult1_c3");
    v(1, 1, 6'h00, 6'h1A, 0, 1, f_ok, "div1_fetch");
    v(1, 1, 6'h00, 6'h1A, 0, 1, dec, "div1_decode");
    v(1, 1, 6'h00, 6'h1A, 0, 1, MST | HW | MDIV | DONE, "div1_c3");
    v(0, 0, 6'h00, 6'h00, 0, 1, 0, "resync4");
    // MEM_WAIT_EN=0 ignores mem_ready
    v(2, 1, 6'h23, 6'h00, 0, 0, f_ok, "nw_fetch");
    v(2, 1, 6'h23, 6'h00, 0, 0, dec, "nw_decode");
    v(2, 1, 6'h23, 6'h00, 0, 0, SA | sb(2), "nw_addr");
    v(2, 1, 6'h23, 6'h00, 0, 0, IOD | MRD, "nw_rd");
    v(2, 1, 6'h23, 6'h00, 0, 0, RW | mtr(1) | DONE, "nw_wb");
    v(0, 0, 6'h00, 6'h00, 0, 1, 0, "resync5");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Hand-written corner case: reset asserted in MEM_WB of lw.
    begin
      vec_t t;
      t.sel = 0; t.z = 0; t.fn = 6'h00; t.op = 6'h23; t.rdy = 1; t.r = 1;
      t.nm = "rstwb_fetch";  t.exp = f_ok;       run_vec(t);
      t.nm = "rstwb_decode"; t.exp = dec;        run_vec(t);
      t.nm = "rstwb_addr";   t.exp = SA | sb(2); run_vec(t);
      t.nm = "rstwb_rd";     t.exp = IOD | MRD;  run_vec(t);
      t.nm = "rstwb_abort";  t.exp = 0; t.r = 0; run_vec(t);
      t.nm = "rstwb_after";  t.exp = f_ok; t.r = 1; run_vec(t);
      t.nm = "rstwb_dec2";   t.exp = dec;        run_vec(t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
